// File: rtl/mux_nx1_pipe.sv
// rtl/mux_nx1_pipe.sv - CHANNELS:1 WIDTH-bit selector with registered valid/ready output and 2-entry skid buffer
// Optional feature macro: MUX_NX1_PIPE_PARITY_EN adds result_par (even parity of the captured word)
module mux_nx1_pipe #(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 4,
    localparam int SEL_W   = $clog2(CHANNELS)
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [CHANNELS*WIDTH-1:0] data_in,
    input  logic [SEL_W-1:0]          select,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [WIDTH-1:0]          result,
    output logic [SEL_W-1:0]          out_channel,
    output logic                      out_valid,
    input  logic                      out_ready,
`ifdef MUX_NX1_PIPE_PARITY_EN
    output logic                      result_par,
`endif
    output logic                      sel_err
);

    // Occupancy of the main (output) register plus the skid register.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic accept;
    logic drain;

    logic [WIDTH-1:0] cap_data;
    logic             cap_in_range;

    logic [WIDTH-1:0] skid_data;
    logic [SEL_W-1:0] skid_chan;

    logic load_main_new;
    logic load_main_skid;
    logic load_skid;

`ifdef MUX_NX1_PIPE_PARITY_EN
    logic cap_par;
    logic skid_par;
`endif

    assign accept = in_valid & in_ready;
    assign drain  = out_valid & out_ready;

    // Channel decode; an index past the last channel yields zeros and is flagged.
    always_comb begin
        cap_data     = '0;
        cap_in_range = 1'b0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (select == SEL_W'(k)) begin
                cap_data     = data_in[k*WIDTH +: WIDTH];
                cap_in_range = 1'b1;
            end
        end
    end

`ifdef MUX_NX1_PIPE_PARITY_EN
    // Parity is fixed at accept time so it stays attached to its word.
    always_comb begin
        cap_par = ^cap_data;
    end
`endif

    // Next occupancy and which register gets loaded this cycle.
    always_comb begin
        state_nxt      = state;
        load_main_new  = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        case (state)
            ST_EMPTY: begin
                if (accept) begin
                    state_nxt     = ST_ONE;
                    load_main_new = 1'b1;
                end
            end
            ST_ONE: begin
                if (accept && drain) begin
                    load_main_new = 1'b1;
                end else if (accept) begin
                    state_nxt = ST_FULL;
                    load_skid = 1'b1;
                end else if (drain) begin
                    state_nxt = ST_EMPTY;
                end
            end
            ST_FULL: begin
                // in_ready is low here, so only a drain can happen.
                if (drain) begin
                    state_nxt      = ST_ONE;
                    load_main_skid = 1'b1;
                end
            end
            default: begin
                state_nxt = ST_EMPTY;
            end
        endcase
    end

    // State register; handshake flags are registered from the next state so
    // in_ready has no combinational path from out_ready.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= ST_EMPTY;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            in_ready  <= (state_nxt != ST_FULL);
            out_valid <= (state_nxt != ST_EMPTY);
        end
    end

    // Main register: takes the new word directly or the parked skid word.
    always_ff @(posedge clock) begin
        if (reset) begin
            result      <= '0;
            out_channel <= '0;
        end else if (load_main_new) begin
            result      <= cap_data;
            out_channel <= select;
        end else if (load_main_skid) begin
            result      <= skid_data;
            out_channel <= skid_chan;
        end
    end

    // Skid register: parks a word accepted while the output is stalled.
    always_ff @(posedge clock) begin
        if (reset) begin
            skid_data <= '0;
            skid_chan <= '0;
        end else if (load_skid) begin
            skid_data <= cap_data;
            skid_chan <= select;
        end
    end

`ifdef MUX_NX1_PIPE_PARITY_EN
    // Parity bit follows its word through main and skid.
    always_ff @(posedge clock) begin
        if (reset) begin
            result_par <= 1'b0;
            skid_par   <= 1'b0;
        end else begin
            if (load_main_new) begin
                result_par <= cap_par;
            end else if (load_main_skid) begin
                result_par <= skid_par;
            end
            if (load_skid) begin
                skid_par <= cap_par;
            end
        end
    end
`endif

    // Sticky error: set by any accepted out-of-range select, cleared only by reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            sel_err <= 1'b0;
        end else if (accept && !cap_in_range) begin
            sel_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mux_nx1_pipe.sv
// tb/tb_mux_nx1_pipe.sv - directed self-checking bench for mux_nx1_pipe (4-channel and 3-channel instances)
module tb_mux_nx1_pipe;

    logic clk;
    int   n_checks;
    int   n_fail;

    // 4-channel instance
    logic         rst4;
    logic [127:0] data4;
    logic [1:0]   sel4;
    logic         iv4;
    logic         ir4;
    logic [31:0]  res4;
    logic [1:0]   ch4;
    logic         ov4;
    logic         or4;
    logic         err4;
`ifdef MUX_NX1_PIPE_PARITY_EN
    logic         par4;
    logic         par3;
`endif

    // 3-channel instance
    logic         rst3;
    logic [95:0]  data3;
    logic [1:0]   sel3;
    logic         iv3;
    logic         ir3;
    logic [31:0]  res3;
    logic [1:0]   ch3;
    logic         ov3;
    logic         or3;
    logic         err3;

    logic [31:0]  exp_word;

    mux_nx1_pipe #(.WIDTH(32), .CHANNELS(4)) dut4 (
        .clock       (clk),
        .reset       (rst4),
        .data_in     (data4),
        .select      (sel4),
        .in_valid    (iv4),
        .in_ready    (ir4),
        .result      (res4),
        .out_channel (ch4),
        .out_valid   (ov4),
        .out_ready   (or4),
`ifdef MUX_NX1_PIPE_PARITY_EN
        .result_par  (par4),
`endif
        .sel_err     (err4)
    );

    mux_nx1_pipe #(.WIDTH(32), .CHANNELS(3)) dut3 (
        .clock       (clk),
        .reset       (rst3),
        .data_in     (data3),
        .select      (sel3),
        .in_valid    (iv3),
        .in_ready    (ir3),
        .result      (res3),
        .out_channel (ch3),
        .out_valid   (ov3),
        .out_ready   (or3),
`ifdef MUX_NX1_PIPE_PARITY_EN
        .result_par  (par3),
`endif
        .sel_err     (err3)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        clk      = 1'b0;
        n_checks = 0;
        n_fail   = 0;

        // Reset held two cycles with in_valid high on both instances
        rst4  = 1'b1;
        rst3  = 1'b1;
        data4 = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
        sel4  = 2'd2;
        iv4   = 1'b1;
        or4   = 1'b1;
        data3 = {32'hCCCCCCCC, 32'hBBBBBBBB, 32'hAAAAAAAA};
        sel3  = 2'd3;
        iv3   = 1'b1;
        or3   = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("rst_in_ready", {31'd0, ir4}, 32'd1);
            check("rst_out_valid", {31'd0, ov4}, 32'd0);
            check("rst_result", res4, 32'd0);
            check("rst_channel", {30'd0, ch4}, 32'd0);
            check("rst_sel_err", {31'd0, err4}, 32'd0);
            check("rst3_sel_err", {31'd0, err3}, 32'd0);
            check("rst3_out_valid", {31'd0, ov3}, 32'd0);
        end
        rst4 = 1'b0;
        rst3 = 1'b0;
        iv4  = 1'b0;
        iv3  = 1'b0;
        tick();
        check("idle_out_valid", {31'd0, ov4}, 32'd0);
        check("idle_in_ready", {31'd0, ir4}, 32'd1);

        // Basic select of channel 2
        iv4  = 1'b1;
        sel4 = 2'd2;
        tick();
        check("basic_out_valid", {31'd0, ov4}, 32'd1);
        check("basic_result", res4, 32'h33333333);
        check("basic_channel", {30'd0, ch4}, 32'd2);
        check("basic_in_ready", {31'd0, ir4}, 32'd1);
        iv4 = 1'b0;
        tick();
        check("basic_drained", {31'd0, ov4}, 32'd0);

        // Back-pressure: selects 0,1,3 with consumer stalled
        or4  = 1'b0;
        iv4  = 1'b1;
        sel4 = 2'd0;
        tick();
        check("bp_first_valid", {31'd0, ov4}, 32'd1);
        check("bp_first_result", res4, 32'h11111111);
        check("bp_first_ready", {31'd0, ir4}, 32'd1);
        sel4 = 2'd1;
        tick();
        check("bp_full_ready", {31'd0, ir4}, 32'd0);
        check("bp_hold_result", res4, 32'h11111111);
        sel4 = 2'd3;
        tick();
        check("bp_held_ready", {31'd0, ir4}, 32'd0);
        check("bp_held_result", res4, 32'h11111111);
        check("bp_held_channel", {30'd0, ch4}, 32'd0);
        check("bp_held_valid", {31'd0, ov4}, 32'd1);
        or4 = 1'b1;
        tick();
        check("bp_out2_result", res4, 32'h22222222);
        check("bp_out2_channel", {30'd0, ch4}, 32'd1);
        check("bp_out2_ready", {31'd0, ir4}, 32'd1);
        tick();
        check("bp_out3_result", res4, 32'h44444444);
        check("bp_out3_channel", {30'd0, ch4}, 32'd3);
        check("bp_out3_valid", {31'd0, ov4}, 32'd1);
        iv4 = 1'b0;
        tick();
        check("bp_empty_valid", {31'd0, ov4}, 32'd0);

        // Reset while full discards both entries
        or4  = 1'b0;
        iv4  = 1'b1;
        sel4 = 2'd0;
        tick();
        sel4 = 2'd1;
        tick();
        check("mid_full_ready", {31'd0, ir4}, 32'd0);
        rst4 = 1'b1;
        iv4  = 1'b0;
        tick();
        check("mid_rst_valid", {31'd0, ov4}, 32'd0);
        check("mid_rst_ready", {31'd0, ir4}, 32'd1);
        check("mid_rst_result", res4, 32'd0);
        check("mid_rst_channel", {30'd0, ch4}, 32'd0);
        rst4 = 1'b0;
        or4  = 1'b1;
        tick();
        check("mid_rst_no_ghost", {31'd0, ov4}, 32'd0);

        // Streaming: 100 random words, one per cycle, each out one cycle later
        or4 = 1'b1;
        iv4 = 1'b1;
        for (int i = 0; i < 100; i++) begin
            data4    = {$urandom, $urandom, $urandom, $urandom};
            sel4     = 2'($urandom_range(0, 3));
            exp_word = data4[sel4*32 +: 32];
            tick();
            check("stream_valid", {31'd0, ov4}, 32'd1);
            check("stream_result", res4, exp_word);
            check("stream_channel", {30'd0, ch4}, {30'd0, sel4});
            check("stream_ready", {31'd0, ir4}, 32'd1);
        end
        iv4 = 1'b0;
        tick();
        check("stream_end_valid", {31'd0, ov4}, 32'd0);
        check("stream_sel_err", {31'd0, err4}, 32'd0);

        // Out-of-range select on the 3-channel instance
        iv3  = 1'b1;
        sel3 = 2'd0;
        tick();
        check("oor_pre_result", res3, 32'hAAAAAAAA);
        check("oor_pre_err", {31'd0, err3}, 32'd0);
        sel3 = 2'd3;
        tick();
        check("oor_result", res3, 32'd0);
        check("oor_channel", {30'd0, ch3}, 32'd3);
        check("oor_valid", {31'd0, ov3}, 32'd1);
        check("oor_err", {31'd0, err3}, 32'd1);
`ifdef MUX_NX1_PIPE_PARITY_EN
        check("oor_par", {31'd0, par3}, 32'd0);
`endif
        sel3 = 2'd1;
        tick();
        check("oor_post1_result", res3, 32'hBBBBBBBB);
        check("oor_post1_err", {31'd0, err3}, 32'd1);
        sel3 = 2'd2;
        tick();
        check("oor_post2_result", res3, 32'hCCCCCCCC);
        check("oor_post2_err", {31'd0, err3}, 32'd1);
        iv3 = 1'b0;
        tick();
        check("oor_idle_err", {31'd0, err3}, 32'd1);
        check("oor_idle_valid", {31'd0, ov3}, 32'd0);
        rst3 = 1'b1;
        tick();
        check("oor_rst_err", {31'd0, err3}, 32'd0);
        rst3 = 1'b0;
        tick();
        check("oor_rst_err_stays", {31'd0, err3}, 32'd0);

`ifdef MUX_NX1_PIPE_PARITY_EN
        // Parity follows the selected word
        data4 = {32'h0, 32'h0, 32'h00000003, 32'h00000007};
        iv4   = 1'b1;
        or4   = 1'b1;
        sel4  = 2'd0;
        tick();
        check("par_result7", res4, 32'h00000007);
        check("par_bit7", {31'd0, par4}, 32'd1);
        sel4 = 2'd1;
        tick();
        check("par_result3", res4, 32'h00000003);
        check("par_bit3", {31'd0, par4}, 32'd0);
        iv4 = 1'b0;
        tick();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
